// File: rtl/complex_integrate_pkg.sv
// Shared precision package for complex_integrate: state encoding, output width
// and the bit positions that split a packed complex word into real/imag parts.
package complex_integrate_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int acc_bits(input int bits, input int length);
    return bits / 2 + $clog2(length);
  endfunction

  // Real part occupies the upper half of the packed word, imaginary the lower.
  function automatic int re_msb(input int bits);
    return bits - 1;
  endfunction

  function automatic int re_lsb(input int bits);
    return bits / 2;
  endfunction

  function automatic int im_msb(input int bits);
    return bits / 2 - 1;
  endfunction

endpackage

// File: rtl/complex_integrate_real_accumulate.sv
// Signed accumulator for one component: sign-extends each input and either
// loads it (first sample of a frame) or adds it to the running total.
module real_accumulate #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [IN_BITS-1:0]  x_i,
  output logic [OUT_BITS-1:0] acc_o,
  output logic [OUT_BITS-1:0] sum_o
);

  logic [OUT_BITS-1:0] acc_q;
  logic [OUT_BITS-1:0] xExt;

  assign xExt  = {{(OUT_BITS - IN_BITS){x_i[IN_BITS-1]}}, x_i};
  // sum_o is the value the accumulator would take this cycle, so the parent
  // can capture a frame total that includes the sample arriving right now.
  assign sum_o = (load_i ? '0 : acc_q) + xExt;
  assign acc_o = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/complex_integrate.sv
// Frame integrator for packed complex samples: sums LENGTH samples per frame and
// hands the total off with valid/ready. Optional macro COMPLEX_INTEGRATE_FLUSH_EN adds a flush input.
module complex_integrate
  import complex_integrate_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 4,
  localparam int ACC_BITS = acc_bits(BITS, LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       a,
`ifdef COMPLEX_INTEGRATE_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*ACC_BITS-1:0] c
);

  localparam int RE_MSB   = re_msb(BITS);
  localparam int RE_LSB   = re_lsb(BITS);
  localparam int IM_MSB   = im_msb(BITS);
  localparam int CNT_BITS = $clog2(LENGTH);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LENGTH - 1);

  state_e                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [2*ACC_BITS-1:0] c_q;
  logic                  outValid_q;

  logic                  accept;
  logic                  emit;
  logic                  accClr;
  logic                  accEn;
  logic                  accLoad;
  logic [ACC_BITS-1:0]   reAcc, imAcc, reSum, imSum;
  logic [2*ACC_BITS-1:0] emitValue;

  assign in_ready  = (state_q == ACCUM) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign c         = c_q;
  assign emitValue = accept ? {reSum, imSum} : {reAcc, imAcc};

  // A frame closes on its last sample (or on flush with something to emit); the
  // accumulators clear at that moment so the next frame starts from zero.
  always_comb begin
    emit = (state_q == ACCUM) && accept && (cnt_q == LAST);
`ifdef COMPLEX_INTEGRATE_FLUSH_EN
    if ((state_q == ACCUM) && flush && (accept || (cnt_q != '0))) begin
      emit = 1'b1;
    end
`endif
    accClr  = emit;
    accEn   = accept && !emit;
    accLoad = (state_q == HOLD) || (cnt_q == '0);
  end

  real_accumulate #(.IN_BITS(BITS / 2), .OUT_BITS(ACC_BITS)) u_re (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accClr),
    .en_i   (accEn),
    .load_i (accLoad),
    .x_i    (a[RE_MSB:RE_LSB]),
    .acc_o  (reAcc),
    .sum_o  (reSum)
  );

  real_accumulate #(.IN_BITS(BITS / 2), .OUT_BITS(ACC_BITS)) u_im (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accClr),
    .en_i   (accEn),
    .load_i (accLoad),
    .x_i    (a[IM_MSB:0]),
    .acc_o  (imAcc),
    .sum_o  (imSum)
  );

  // In HOLD a sample taken alongside the handoff is sample 1 of the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      c_q        <= '0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (emit) begin
            c_q        <= emitValue;
            cnt_q      <= '0;
            outValid_q <= 1'b1;
            state_q    <= HOLD;
          end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= ACCUM;
            cnt_q      <= accept ? CNT_BITS'(1) : '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/complex_integrate.md
COMPLEX_INTEGRATE -- requirements
Module: complex_integrate

Interface
REQ-001 SHALL have parameter BITS, default 16: packed complex input width; real part in [BITS-1:BITS/2], imaginary part in [BITS/2-1:0], signed two's complement.
REQ-002 SHALL have parameter LENGTH, default 4: samples summed per frame; legal range 2..65536.
REQ-003 SHALL define localparam ACC_BITS = BITS/2 + clog2(LENGTH): width of each output component.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input sample present.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the sample this cycle.
REQ-008 SHALL have port a, input, BITS wide: complex sample.
REQ-009 SHALL have port out_valid, output, 1 bit: frame sum present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the sum.
REQ-011 SHALL have port c, output, 2*ACC_BITS wide: complex sum; real part in the upper half.

Function
REQ-012 SHALL treat a sample as accepted when in_valid && in_ready.
REQ-013 SHALL sum real and imaginary parts independently, sign-extended to ACC_BITS; no overflow is possible by construction.
REQ-014 SHALL implement states ACCUM and HOLD; in ACCUM, out_valid=0 and in_ready=1.
REQ-015 SHALL keep a sample counter 0..LENGTH-1; it increments per accepted sample and wraps to 0 on the LENGTH-th.
REQ-016 SHALL, on acceptance of the LENGTH-th sample, register c = sum of all LENGTH samples and enter HOLD; out_valid rises the following cycle (latency 1).
REQ-017 SHALL, in HOLD, hold c and out_valid=1 stable until out_ready=1, then return to ACCUM.
REQ-018 SHALL, in HOLD, drive in_ready = out_ready; a sample accepted in the same cycle as the output handoff becomes sample 1 of the next frame (accumulator loaded with that sample, counter=1).
REQ-019 SHALL clear the accumulator on every frame boundary, so no residue carries between frames.
REQ-020 SHALL ignore a inputs when in_valid=0.

Reset
REQ-021 SHALL, when rst asserts, immediately force state=ACCUM, counter=0, accumulators=0, c=0, out_valid=0; in_ready=1 after release.
REQ-022 SHALL discard a partial frame or a pending HOLD result on reset; the first sample after release is sample 1.

Configuration
REQ-023 SHALL, with COMPLEX_INTEGRATE_FLUSH_EN defined, add a 1-bit input flush; flush=1 in ACCUM with counter>0 emits the partial sum (including any sample accepted that cycle) via HOLD exactly as REQ-016, then restarts the count.
REQ-024 SHALL treat flush with counter=0 and no accepted sample as a no-op; flush in HOLD is ignored.
REQ-025 SHALL, without COMPLEX_INTEGRATE_FLUSH_EN, omit the flush port and logic entirely.

Structure
REQ-026 SHALL take acc_bits(), complex real/imag split helpers and the ACCUM/HOLD state enum from the shared precision package.
REQ-027 SHALL instantiate sub-module real_accumulate (BITS/2 in, ACC_BITS out, load/add/enable) twice, once for the real part and once for the imaginary part; the FSM and counter live in complex_integrate.

Verification (BITS=16, LENGTH=4)
REQ-028 SHALL check basic operation: samples (1,-1),(2,-1),(3,-1),(4,-1), out_ready=1 -> one cycle after the 4th sample, out_valid=1 with c=(10,-4) for exactly one cycle.
REQ-029 SHALL check extremes: 4x(127,-128) -> c=(508,-512), both 10-bit components exact.
REQ-030 SHALL check backpressure: out_ready=0 for 5 cycles after the frame -> c held stable, in_ready=0; on out_ready=1 with a simultaneous sample (5,5), the next frame of 4x(5,5) gives (20,20).
REQ-031 SHALL check reset mid-frame: 2 samples of (7,7), pulse rst, then 4x(1,1) -> c=(4,4).
REQ-032 SHALL check flush (macro defined): samples (3,2),(3,2), then flush=1 -> c=(6,4); the next full frame is unaffected.
